// File: rtl/cnt_seq.sv
// Run sequencer around an N-bit up-counter: loads D, steps once per PRESCALE
// cycles up to target, then stops (one-shot) or reloads (periodic).
module cnt_seq #(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         periodic,
  input  logic [N-1:0] D,
  input  logic [N-1:0] target,
  output logic [N-1:0] cnt,
  output logic         done,
  output logic         busy,
  output logic         paused,
  output logic [2:0]   state
);

  // Control inputs are single-cycle strobes with no ready: a strobe is acted on
  // at the edge it is sampled, ranked abort > start > pause > prescaler tick.

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pre_q;
  logic [N-1:0]  cnt_q;
  logic [N-1:0]  target_q;
  logic          periodic_q;
  logic          done_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      cnt_q      <= '0;
      target_q   <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        pre_q   <= '0;
        cnt_q   <= '0;
      end else if (start) begin
        target_q   <= target;
        periodic_q <= periodic;
        state_q    <= S_LOAD;
      end else begin
        unique case (state_q)
          S_LOAD: begin
            cnt_q   <= D;
            pre_q   <= '0;
            state_q <= S_RUN;
          end
          S_RUN: begin
            // A pause landing on a tick edge swallows that tick entirely.
            if (pause) begin
              state_q <= S_PAUSE;
            end else if (pre_q == PRE_LAST) begin
              pre_q <= '0;
              if (cnt_q == target_q) begin
                done_q <= 1'b1;
                if (periodic_q) cnt_q   <= D;
                else            state_q <= S_DONE;
              end else begin
                cnt_q <= cnt_q + N'(1);
              end
            end else begin
              pre_q <= pre_q + PW'(1);
            end
          end
          S_PAUSE: begin
            if (pause) state_q <= S_RUN;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign cnt    = cnt_q;
  assign done   = done_q;
  assign state  = state_q;
  assign busy   = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_PAUSE);
  assign paused = (state_q == S_PAUSE);

endmodule

// File: tb/tb_cnt_seq.sv
// Bench for cnt_seq: three instances (PRESCALE 1..3) on shared inputs, checked
// every cycle against a run-length model plus directed scenario checks.
module tb_cnt_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       start, pause, abort, periodic;
  logic [3:0] d_in, target;

  logic [3:0] cnt_o    [3];
  logic       done_o   [3];
  logic       busy_o   [3];
  logic       paused_o [3];
  logic [2:0] state_o  [3];

  int total = 0;
  int bad   = 0;

  // model: count value is base + (run cycles / prescale), modulo 16
  int m_st[3], m_cnt[3], m_done[3], m_base[3], m_run[3], m_tq[3], m_pq[3];

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cnt_seq #(.N(4), .PRESCALE(g + 1)) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (start),
      .pause     (pause),
      .abort     (abort),
      .periodic  (periodic),
      .D         (d_in),
      .target    (target),
      .cnt       (cnt_o[g]),
      .done      (done_o[g]),
      .busy      (busy_o[g]),
      .paused    (paused_o[g]),
      .state     (state_o[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_base[k] = 0;
      m_run[k] = 0; m_tq[k] = 0; m_pq[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int p;
      int c;
      p = k + 1;
      m_done[k] = 0;
      if (abort) begin
        m_st[k] = 0; m_cnt[k] = 0; m_run[k] = 0;
      end else if (start) begin
        m_tq[k] = target; m_pq[k] = periodic; m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        m_base[k] = d_in; m_run[k] = 0; m_st[k] = 2;
      end else if (m_st[k] == 2) begin
        if (pause) m_st[k] = 3;
        else if ((m_run[k] % p) == p - 1) begin
          c = (m_base[k] + m_run[k] / p) % 16;
          if (c == m_tq[k]) begin
            m_done[k] = 1;
            if (m_pq[k] != 0) begin m_base[k] = d_in; m_run[k] = 0; end
            else m_st[k] = 4;
          end else m_run[k]++;
        end else m_run[k]++;
      end else if (m_st[k] == 3) begin
        if (pause) m_st[k] = 2;
      end
      if (m_st[k] == 2 || m_st[k] == 3) m_cnt[k] = (m_base[k] + m_run[k] / p) % 16;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cnt%0d", k),    cnt_o[k],    m_cnt[k]);
      check($sformatf("done%0d", k),   done_o[k],   m_done[k]);
      check($sformatf("state%0d", k),  state_o[k],  m_st[k]);
      check($sformatf("busy%0d", k),   busy_o[k],   (m_st[k] >= 1 && m_st[k] <= 3));
      check($sformatf("paused%0d", k), paused_o[k], (m_st[k] == 3));
    end
  endtask

  // One clock: model consumes the inputs now on the pins, DUTs see the same edge.
  task automatic cycle();
    if (!sys_rst_n) model_reset();
    else model_step();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; pause = 0; abort = 0;
  endtask

  task automatic launch(input int dv, input int tv, input int per);
    d_in = 4'(dv); target = 4'(tv); periodic = per[0];
    start = 1; cycle(); start = 0;
  endtask

  task automatic run_basic();
    launch(3, 6, 0);
    check("b_load_state", state_o[0], 1);
    cycle();
    check("b_cnt3", cnt_o[0], 3);
    check("b_run_state", state_o[0], 2);
    cycle(); check("b_cnt4", cnt_o[0], 4);
    cycle(); check("b_cnt5", cnt_o[0], 5);
    cycle(); check("b_cnt6", cnt_o[0], 6);
    check("b_nodone_yet", done_o[0], 0);
    cycle();
    check("b_done", done_o[0], 1);
    check("b_done_state", state_o[0], 4);
    check("b_hold6", cnt_o[0], 6);
    check("b_busy", busy_o[0], 0);
    cycle();
    check("b_done_once", done_o[0], 0);
    check("b_still_done", state_o[0], 4);
  endtask

  initial begin
    int t_a, t_b, last, gaps, nb, found;
    sys_rst_n = 0; d_in = 0; target = 0; periodic = 0;
    idle_inputs();
    model_reset();
    repeat (3) cycle();
    check("rst_cnt", cnt_o[0], 0);
    check("rst_state", state_o[0], 0);
    sys_rst_n = 1;
    repeat (2) cycle();

    run_basic();

    // wrap-around one-shot
    launch(14, 1, 0);
    exp_q = '{14, 15, 0, 1};
    got_q.delete();
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (state_o[0] == 2) got_q.push_back(32'(cnt_o[0]));
      if (done_o[0]) nb++;
    end
    check("w_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("w_seq%0d", i), got_q[i], exp_q[i]);
    check("w_done_cnt", nb, 1);
    check("w_final", state_o[0], 4);

    // periodic on PRESCALE=2 instance
    launch(2, 4, 1);
    last = -1; gaps = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (i > 0 && !busy_o[1]) nb++;
      if (done_o[1]) begin
        if (last >= 0) begin check("p_gap", i - last, 6); gaps++; end
        last = i;
      end
    end
    check("p_gaps_seen", gaps >= 4, 1);
    check("p_busy_drop", nb, 0);
    abort = 1; cycle(); abort = 0;

    // pause/resume on PRESCALE=3 instance
    launch(0, 5, 0);
    t_a = 1; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(); t_a++;
      if (done_o[2]) found = 1;
    end
    check("u_found", found, 1);
    check("u_latency", t_a, 2 + ((5 - 0) % 16 + 1) * 3);

    launch(0, 5, 0);
    t_b = 1; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(); t_b++;
      if (cnt_o[2] == 2 && state_o[2] == 2) found = 1;
    end
    check("u_reach2", found, 1);
    pause = 1; cycle(); pause = 0; t_b++;
    for (int i = 0; i < 8; i++) begin
      cycle(); t_b++;
      check("u_paused", paused_o[2], 1);
      check("u_frozen", cnt_o[2], 2);
    end
    pause = 1; cycle(); pause = 0; t_b++;
    check("u_resumed", state_o[2], 2);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(); t_b++;
      if (done_o[2]) found = 1;
    end
    check("u_found2", found, 1);
    check("u_delay", t_b - t_a, 10);

    // priority
    launch(0, 15, 0);
    repeat (3) cycle();
    start = 1; abort = 1; cycle(); idle_inputs();
    check("pr_abort_state", state_o[0], 0);
    check("pr_abort_cnt", cnt_o[0], 0);
    launch(0, 15, 0);
    repeat (3) cycle();
    start = 1; pause = 1; cycle(); idle_inputs();
    check("pr_restart", state_o[0], 1);
    repeat (3) cycle();
    t_a = cnt_o[0];
    pause = 1; cycle(); pause = 0;
    check("pr_tick_swallowed", cnt_o[0], t_a);
    check("pr_paused", paused_o[0], 1);

    // asynchronous reset between edges
    launch(3, 6, 0);
    repeat (2) cycle();
    #2 sys_rst_n = 0;
    #1;
    check("ar_cnt", cnt_o[0], 0);
    check("ar_state", state_o[0], 0);
    check("ar_done", done_o[0], 0);
    model_reset();
    repeat (2) cycle();
    sys_rst_n = 1;
    repeat (10) cycle();
    run_basic();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 39) == 0);
      abort    = ($urandom_range(0, 79) == 0);
      pause    = ($urandom_range(0, 14) == 0);
      periodic = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) d_in = 4'($urandom_range(0, 15));
      target   = 4'($urandom_range(0, 15));
      cycle();
    end
    idle_inputs();
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
